// File: rtl/aes_round_sequencer.sv
// Control sequencer for the iterative AES-128 decryption datapath.
// Moore FSM that issues op selects, column selects, round-key indices and load strobes.
module aes_round_sequencer #(
  parameter int KEYEXP_CYCLES = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  output logic [2:0] op_sel,
  output logic       state_ld,
  output logic [1:0] col_sel,
  output logic [3:0] round_key_idx,
  output logic       keyexp_en,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ARK  = 3'd2;
  localparam logic [2:0] OP_ISR  = 3'd3;
  localparam logic [2:0] OP_ISB  = 3'd4;
  localparam logic [2:0] OP_IMC  = 3'd5;

  localparam logic [7:0] KX_LAST = 8'(KEYEXP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_KEYEXP, S_ARK_INIT,
    S_ISR, S_ISB, S_ARK, S_IMC,
    S_ISR_F, S_ISB_F, S_ARK_F, S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] round_reg, round_next;
  logic [7:0] kx_cnt_reg, kx_cnt_next;
  logic [1:0] col_reg, col_next;
  logic       busy_state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= S_IDLE;
      round_reg  <= 4'd0;
      kx_cnt_reg <= 8'd0;
      col_reg    <= 2'd0;
    end else begin
      state_reg  <= state_next;
      round_reg  <= round_next;
      kx_cnt_reg <= kx_cnt_next;
      col_reg    <= col_next;
    end
  end

  assign busy_state = (state_reg != S_IDLE) && (state_reg != S_DONE);

  always_comb begin
    state_next  = state_reg;
    round_next  = round_reg;
    kx_cnt_next = kx_cnt_reg;
    col_next    = col_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD: begin
        state_next  = S_KEYEXP;
        kx_cnt_next = KX_LAST;
      end
      S_KEYEXP: begin
        if (kx_cnt_reg == 8'd0) state_next = S_ARK_INIT;
        else                    kx_cnt_next = kx_cnt_reg - 8'd1;
      end
      S_ARK_INIT: begin
        state_next = S_ISR;
        round_next = 4'd9;
      end
      S_ISR: state_next = S_ISB;
      S_ISB: state_next = S_ARK;
      S_ARK: begin
        state_next = S_IMC;
        col_next   = 2'd0;
      end
      S_IMC: begin
        if (col_reg == 2'd3) begin
          // Round count saturates at 0; the last IMC burst hands over to the final round.
          round_next = (round_reg != 4'd0) ? round_reg - 4'd1 : 4'd0;
          state_next = (round_reg <= 4'd1) ? S_ISR_F : S_ISR;
          col_next   = 2'd0;
        end else begin
          col_next = col_reg + 2'd1;
        end
      end
      S_ISR_F: state_next = S_ISB_F;
      S_ISB_F: state_next = S_ARK_F;
      S_ARK_F: state_next = S_DONE;
      S_DONE:  if (!start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Dropping start aborts any in-flight operation without a further state write.
    if (busy_state && !start) state_next = S_IDLE;
  end

  always_comb begin
    op_sel        = OP_HOLD;
    state_ld      = 1'b0;
    col_sel       = 2'd0;
    round_key_idx = 4'd0;
    keyexp_en     = 1'b0;
    busy          = busy_state;
    done          = 1'b0;
    case (state_reg)
      S_LOAD: begin
        op_sel        = OP_LOAD;
        state_ld      = 1'b1;
        round_key_idx = 4'd10;
      end
      S_KEYEXP: begin
        keyexp_en     = 1'b1;
        round_key_idx = 4'd10;
      end
      S_ARK_INIT: begin
        op_sel        = OP_ARK;
        state_ld      = 1'b1;
        round_key_idx = 4'd10;
      end
      S_ISR: begin
        op_sel        = OP_ISR;
        state_ld      = 1'b1;
        round_key_idx = round_reg;
      end
      S_ISB: begin
        op_sel        = OP_ISB;
        state_ld      = 1'b1;
        round_key_idx = round_reg;
      end
      S_ARK: begin
        op_sel        = OP_ARK;
        state_ld      = 1'b1;
        round_key_idx = round_reg;
      end
      S_IMC: begin
        op_sel        = OP_IMC;
        state_ld      = 1'b1;
        col_sel       = col_reg;
        round_key_idx = round_reg;
      end
      S_ISR_F: begin
        op_sel   = OP_ISR;
        state_ld = 1'b1;
      end
      S_ISB_F: begin
        op_sel   = OP_ISB;
        state_ld = 1'b1;
      end
      S_ARK_F: begin
        op_sel   = OP_ARK;
        state_ld = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a position-based model predicts every output each cycle
// for a K=10 and a K=1 instance, plus directed latency, count and abort/reset checks.
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst0, start0, rst1, start1;
  logic [2:0] op0, op1;
  logic       ld0, ld1, kx0, kx1, busy0, busy1, done0, done1;
  logic [1:0] col0, col1;
  logic [3:0] rk0, rk1;
  logic [12:0] vec0, vec1;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pos0 = -1;
  int pos1 = -1;
  bit chk_en = 0;

  aes_round_sequencer #(.KEYEXP_CYCLES(10)) dut (
    .Clk(clk), .Reset(rst0), .start(start0), .op_sel(op0), .state_ld(ld0),
    .col_sel(col0), .round_key_idx(rk0), .keyexp_en(kx0), .busy(busy0), .done(done0)
  );

  aes_round_sequencer #(.KEYEXP_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(rst1), .start(start1), .op_sel(op1), .state_ld(ld1),
    .col_sel(col1), .round_key_idx(rk1), .keyexp_en(kx1), .busy(busy1), .done(done1)
  );

  // Field layout: op[12:10] ld[9] col[8:7] rk[6:3] kx[2] busy[1] done[0]
  assign vec0 = {op0, ld0, col0, rk0, kx0, busy0, done0};
  assign vec1 = {op1, ld1, col1, rk1, kx1, busy1, done1};

  initial clk = 0;
  always #5 clk = ~clk;

  // Expected outputs at operation position p (-1 idle, 0..k+67 busy, k+68 done).
  function automatic logic [12:0] exp_vec(input int k, input int p);
    logic [2:0] op; logic ld; logic [1:0] col; logic [3:0] rk; logic kx, bz, dn;
    int q, s;
    op = 0; ld = 0; col = 0; rk = 0; kx = 0; bz = 0; dn = 0; q = 0; s = 0;
    if (p == k + 68) dn = 1;
    else if (p >= 0) begin
      bz = 1; ld = 1;
      if (p == 0) begin op = 1; rk = 10; end
      else if (p <= k) begin ld = 0; kx = 1; rk = 10; end
      else if (p == k + 1) begin op = 2; rk = 10; end
      else if (p <= k + 64) begin
        q = p - k - 2; s = q % 7; rk = 4'(9 - q / 7);
        case (s)
          0: op = 3;
          1: op = 4;
          2: op = 2;
          default: begin op = 5; col = 2'(s - 3); end
        endcase
      end else begin
        rk = 0;
        op = (p == k + 65) ? 3'd3 : (p == k + 66) ? 3'd4 : 3'd2;
      end
    end
    return {op, ld, col, rk, kx, bz, dn};
  endfunction

  function automatic int next_pos(input int k, input int p, input logic st, input logic rs);
    if (rs) return -1;
    if (p == -1) return st ? 0 : -1;
    if (p == k + 68) return st ? p : -1;
    if (!st) return -1;
    return p + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    pos0 <= next_pos(10, pos0, start0, rst0);
    pos1 <= next_pos(1, pos1, start1, rst1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("trace_k10", int'(vec0), int'(exp_vec(10, pos0)));
      chk("trace_k1", int'(vec1), int'(exp_vec(1, pos1)));
    end
  end

  // Call with start already high; the next posedge is E0. Returns at the negedge showing done.
  task automatic measure(input int which, output int lat, output int nb, output int nld, output int nkx);
    int t0;
    bit seen;
    lat = -1; nb = 0; nld = 0; nkx = 0; seen = 0;
    @(posedge clk); #1 t0 = cyc;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (which == 0) begin
        nb += int'(busy0); nld += int'(ld0); nkx += int'(kx0); seen = done0;
      end else begin
        nb += int'(busy1); nld += int'(ld1); nkx += int'(kx1); seen = done1;
      end
      if (seen) lat = cyc - t0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] v;
    int lat, nb, nld, nkx, sum, cnt;
    bit found;

    // Pin the model with hand-derived values.
    v = exp_vec(10, 0);  chk("pin_load_op", int'(v[12:10]), 1); chk("pin_load_rk", int'(v[6:3]), 10);
    v = exp_vec(10, 11); chk("pin_arkinit_op", int'(v[12:10]), 2); chk("pin_arkinit_rk", int'(v[6:3]), 10);
    v = exp_vec(10, 14); chk("pin_ark9_op", int'(v[12:10]), 2); chk("pin_ark9_rk", int'(v[6:3]), 9);
    v = exp_vec(10, 45); chk("pin_r5c2_op", int'(v[12:10]), 5); chk("pin_r5c2_col", int'(v[8:7]), 2);
    chk("pin_r5c2_rk", int'(v[6:3]), 5);
    v = exp_vec(10, 77); chk("pin_arkf_op", int'(v[12:10]), 2); chk("pin_arkf_rk", int'(v[6:3]), 0);
    v = exp_vec(10, 78); chk("pin_done", int'(v), 1);
    sum = 0;
    for (int p = 0; p < 78; p++) begin v = exp_vec(10, p); sum += int'(v[9]); end
    chk("pin_ld_total", sum, 68);

    rst0 = 1; rst1 = 1; start0 = 0; start1 = 0;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(vec0), 0);
    rst0 = 0; rst1 = 0;
    @(negedge clk);

    // Full run, K=10.
    start0 = 1;
    measure(0, lat, nb, nld, nkx);
    $display("run1: latency=%0d busy=%0d ld=%0d kx=%0d", lat, nb, nld, nkx);
    chk("run1_latency", lat, 78);
    chk("run1_busy_cycles", nb, 78);
    chk("run1_ld_pulses", nld, 68);
    chk("run1_keyexp_cycles", nkx, 10);

    // Held start after done.
    cnt = 0;
    repeat (20) begin @(negedge clk); if (done0 && !busy0) cnt++; end
    $display("held: done cycles=%0d", cnt);
    chk("held_done", cnt, 20);
    start0 = 0;
    @(negedge clk);
    chk("done_falls", int'(done0), 0);
    start0 = 1;
    measure(0, lat, nb, nld, nkx);
    $display("run2: latency=%0d", lat);
    chk("run2_latency", lat, 78);
    start0 = 0;
    repeat (3) @(negedge clk);

    // Abort at round 5 IMC col 2.
    start0 = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (op0 == 3'd5 && col0 == 2'd2 && rk0 == 4'd5) found = 1;
    end
    chk("abort_reach", int'(found), 1);
    start0 = 0;
    @(negedge clk);
    chk("abort_outputs", int'(vec0), 0);
    cnt = 0;
    repeat (90) begin @(negedge clk); cnt += int'(done0); end
    $display("abort: done cycles after abort=%0d", cnt);
    chk("abort_no_done", cnt, 0);

    // Reset during KEYEXP cycle 4 with start held.
    start0 = 1;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 4; i++) begin
      @(negedge clk);
      cnt += int'(kx0);
    end
    chk("reset_reach_kx4", cnt, 4);
    rst0 = 1;
    @(negedge clk);
    chk("reset_mid_outputs", int'(vec0), 0);
    rst0 = 0;
    measure(0, lat, nb, nld, nkx);
    $display("run_after_reset: latency=%0d", lat);
    chk("after_reset_latency", lat, 78);
    start0 = 0;
    repeat (2) @(negedge clk);

    // K=1 instance.
    start1 = 1;
    measure(1, lat, nb, nld, nkx);
    $display("run_k1: latency=%0d kx=%0d ld=%0d", lat, nkx, nld);
    chk("k1_latency", lat, 69);
    chk("k1_keyexp_cycles", nkx, 1);
    chk("k1_ld_pulses", nld, 68);
    start1 = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM for the iterative AES-128 decryption datapath behind the memory-mapped AES register interface. It turns the single-bit start/done handshake into the per-cycle operation selects, column selects, round-key indices and state-register load strobes that drive InvShiftRows, InvSubBytes, AddRoundKey and the one-column-per-cycle InvMixColumns unit. It holds no datapath bits; it only sequences them.

## Interface
- KEYEXP_CYCLES, default 10: cycles the key-expansion unit needs after keyexp_en rises; legal range 1..255.
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- start  in  1  level request from the start register; bit 0 only.
- op_sel  out  3  datapath mux select: 0 hold, 1 load ciphertext, 2 AddRoundKey, 3 InvShiftRows, 4 InvSubBytes, 5 InvMixColumns.
- state_ld  out  1  write strobe for the 128-bit state register (one 32-bit column only when op_sel=5).
- col_sel  out  2  column written or processed by InvMixColumns; 0 when op_sel≠5.
- round_key_idx  out  4  round-key select into the expanded schedule, 0..10.
- keyexp_en  out  1  high while key expansion runs.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  result valid; feeds the done register.

## Operation
- Reset is synchronous, active-high; clock Clk. Reset forces IDLE at the next edge, from any state, including mid-decryption.
- All outputs are Moore outputs decoded from registered state and counters only, with no path from start. Reset and IDLE values are all zero.
- States and transitions:
  - IDLE: go to LOAD when start=1.
  - LOAD: 1 cycle; op_sel=1, state_ld=1, round_key_idx=10.
  - KEYEXP: KEYEXP_CYCLES cycles; keyexp_en=1, op_sel=0, round_key_idx=10.
  - ARK_INIT: 1 cycle; op_sel=2, state_ld=1, round_key_idx=10.
  - Rounds r = 9 down to 1, each 7 cycles in this order:
    - ISR: op_sel=3.
    - ISB: op_sel=4.
    - ARK: op_sel=2, round_key_idx=r.
    - IMC: 4 cycles, op_sel=5, col_sel=0,1,2,3.
    - state_ld=1 in every round cycle; round_key_idx=r in all 7 cycles.
  - Final: ISR_F, ISB_F, ARK_F, 1 cycle each; same encodings as above, round_key_idx=0.
  - DONE: done=1, op_sel=0, state_ld=0, round_key_idx=0. Stay while start=1. Go to IDLE when start=0.
- Abort: start=0 in any busy state returns to IDLE at the next edge.
  - done stays 0.
  - The state register is not written in the cycle after the edge that sampled start=0.
- No restart while start is held high after done. A new decryption needs start to fall and rise again.
- The round counter is 4 bits, decrements only on leaving IMC col 3, and never wraps below 0.
- The KEYEXP counter is 8 bits. It is reloaded on entering KEYEXP, so back-to-back operations are independent.

## Timing
- Let E0 be the edge that samples start=1 in IDLE. The FSM occupies:
  - LOAD after E0.
  - KEYEXP after E1..E(K), where K=KEYEXP_CYCLES.
  - ARK_INIT after E(K+1).
  - Rounds after E(K+2)..E(K+64).
  - ISR_F, ISB_F, ARK_F after E(K+65), E(K+66), E(K+67).
  - DONE after E(K+68).
- Start-to-done latency: K+68 cycles, which is 78 at the default.
- busy is high for exactly K+68 cycles.
- done falls one cycle after the edge that samples start=0 in DONE.
- Minimum start-low gap between operations: 1 cycle, spent in IDLE.
- Total state_ld pulses per full operation: 1 + 1 + 9×7 + 3 = 68.

## Test plan
- Reset, then start=1 with K=10:
  - done rises exactly 78 cycles after E0; busy high for 78 cycles.
  - op_sel trace is 1, 0×10, 2, then (3,4,2,5,5,5,5)×9, then 3,4,2.
  - Exactly 68 state_ld pulses.
- Round-key check, same run:
  - round_key_idx is 10 during LOAD, KEYEXP and ARK_INIT.
  - Each ARK cycle shows 9,8,…,1 in order; ARK_F shows 0.
  - col_sel steps 0,1,2,3 in every IMC burst and is 0 elsewhere.
- Held start:
  - Keep start=1 for 20 cycles after done; FSM stays in DONE with done=1 and busy=0.
  - Drop start; done=0 next cycle; raise start again; a second run gives identical latency.
- Abort: drop start during round 5 IMC col 2 -> IDLE next edge, done never asserts, all outputs 0.
- Reset mid-operation:
  - Assert Reset during KEYEXP cycle 4 with start held high -> all outputs 0 the next cycle.
  - After Reset releases, a fresh run starts and completes in 78 cycles.
- KEYEXP_CYCLES=1 build: latency 69; LOAD is followed by exactly one keyexp_en cycle.
